demux_dispatcher: RTL
=====================

Name: demux_dispatcher

Overview:
- Clocked controller that sequences a 1-to-4 demultiplexer. It steers a stream of WIDTH-bit words from one valid/ready input to four output channels W, X, Y and Z.
- Destination is either taken from the word itself (directed mode) or chosen by an internal round-robin pointer (round-robin mode).
- Each channel has a one-entry output register with its own valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits between the upstream word source and the four downstream consumers, replacing free-running SEL drive with a handshaked scheduler.

Parameters:
- WIDTH, 2, data word width; same width on the input and on W/X/Y/Z.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  input data word.
- dest  input  2  destination channel for directed mode (0=W, 1=X, 2=Y, 3=Z).
- in_valid  input  1  A/dest are valid.
- in_ready  output  1  dispatcher accepts the word this cycle.
- mode  input  1  0 = directed (use dest); 1 = round-robin (use internal pointer).
- W  output  WIDTH  channel 0 data.
- X  output  WIDTH  channel 1 data.
- Y  output  WIDTH  channel 2 data.
- Z  output  WIDTH  channel 3 data.
- out_valid  output  4  per-channel valid; bit0=W … bit3=Z.
- out_ready  input  4  per-channel consumer ready; bit0=W … bit3=Z.
- SEL  output  2  current target channel (dest or pointer, per mode).
- acc_cnt  output  CNT_W  total words accepted.

Behaviour:
- Reset, synchronous on the rising clk edge while rst=1:
  - W/X/Y/Z = 0, out_valid = 0, round-robin pointer = 0, acc_cnt = 0.
  - in_ready is forced to 0 while rst=1.
- Target selection, combinational: SEL = dest when mode=0, otherwise the pointer.
- in_ready:
  - in_ready = ~out_valid[SEL] | out_ready[SEL].
  - The target register must be empty, or draining in the same cycle (pass-through ready).
  - in_ready never depends on in_valid.
- Accept = in_valid & in_ready. On accept:
  - The target channel register loads A.
  - out_valid[SEL] = 1 in the next cycle, giving 1 cycle of latency from accept to output valid.
- Channel drain:
  - When out_valid[i] & out_ready[i] and channel i is not loaded in that same cycle, out_valid[i] clears next cycle.
  - Simultaneous drain and load on one channel: out_valid stays 1 and the data takes the new word.
- Data hold:
  - Channel data registers change only on a load.
  - When out_valid[i]=0 they hold their last value and are not zeroed.
  - Non-target channels are never disturbed.
- Round-robin pointer:
  - Advances by 1 only on an accept while mode=1; wraps 3→0.
  - Strict order: there is no skipping. If the pointed channel is full and not draining, the input stalls even if other channels are free.
  - In mode=0 the pointer holds its value.
- Mode change:
  - mode is sampled combinationally each cycle.
  - Switching mode does not reset the pointer; a return to round-robin resumes from the held pointer.
- dest is ignored when mode=1.
- acc_cnt: +1 on every accept; wraps modulo 2^CNT_W.
- Consumer rule: out_ready may toggle freely. out_valid, once set, stays set and its data stays stable until the handshake completes.
- Reset mid-operation: all pending channel words are discarded; no partial transfer survives.

Decomposition:
- Package demux_pkg holds:
  - Channel index constants CH_W=0, CH_X=1, CH_Y=2, CH_Z=3.
  - NCH=4.
  - MODE_DIRECT=0, MODE_RR=1.
- Sub-module demux_chan_reg, instantiated 4×, is a one-entry valid/ready register with:
  - inputs load, d, ready;
  - outputs valid, q, and space = ~valid | ready.
- Top level contains target select, the in_ready mux, the pointer, and the counter.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, A=2'b11 → in_ready=0, out_valid=4'b0000, W..Z=0, acc_cnt=0, SEL=0.
- Directed: mode=0, out_ready=4'hF, send (A,dest) = (1,0),(2,1),(3,2),(0,3) on consecutive cycles → each out_valid bit pulses one cycle after its accept; W=1, X=2, Y=3, Z=0; acc_cnt=4.
- Round-robin wrap: mode=1, out_ready=4'hF, send 5 words 3,2,1,0,3 → they land on W,X,Y,Z,W in order; SEL reads 0,1,2,3,0 at each accept; pointer ends at 1.
- Backpressure stall: mode=1, out_ready=4'b1110, W already full → in_ready=0 while pointer=0, and X/Y/Z stay untouched. Raise out_ready[0] → W drains and the new word loads in the same cycle, with out_valid[0] remaining 1.
- Mode switch: round-robin accepts 2 words (pointer=2), switch to mode=0 with dest=3 → word goes to Z and pointer stays 2. Switch back to mode=1 → next word goes to Y.
- Reset mid-stream: out_valid=4'b1011 with out_ready=0, assert rst for 1 cycle → out_valid=0, pointer=0, acc_cnt=0; the next accept lands on W.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the 1-to-4 demux dispatcher.
//   NCH           number of output channels
//   CH_W..CH_Z    channel indices (also the SEL encoding)
//   MODE_DIRECT   take the destination from the word's dest field
//   MODE_RR       take the destination from the round-robin pointer
package demux_pkg;

  localparam int NCH = 4;

  localparam logic [1:0] CH_W = 2'd0;
  localparam logic [1:0] CH_X = 2'd1;
  localparam logic [1:0] CH_Y = 2'd2;
  localparam logic [1:0] CH_Z = 2'd3;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/demux_chan_reg.sv
// demux_chan_reg: one-entry output register with a valid/ready handshake.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   load       write d into the entry this cycle
//   d          incoming word
//   ready      downstream consumer ready
//   valid      entry holds a word for the consumer
//   q          held word; changes only on load, never zeroed on drain
//   space      entry can take a word this cycle (empty, or draining now)
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             space
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      // A load wins over a same-cycle drain: the old word leaves, the new
      // one takes its place and valid never drops.
      valid <= 1'b1;
      q     <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign space = ~valid | ready;

endmodule

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: handshaked 1-to-4 demux scheduler.
// Steers WIDTH-bit words from one valid/ready input to channels W/X/Y/Z,
// each backed by its own one-entry register so a stalled consumer blocks
// only its own channel.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   A, dest, in_valid   input word, directed destination, word valid
//   in_ready            word is accepted this cycle (when in_valid)
//   mode                0 = directed (dest), 1 = round-robin (pointer)
//   W, X, Y, Z          channel data
//   out_valid/out_ready per-channel handshake, bit0=W .. bit3=Z
//   SEL                 current target channel
//   acc_cnt             running count of accepted words (wraps)
module demux_dispatcher
  import demux_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       dest,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  output logic [WIDTH-1:0] W,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [1:0]       SEL,
  output logic [CNT_W-1:0] acc_cnt
);

  logic [1:0]       ptr;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   space;
  logic [WIDTH-1:0] q [NCH];
  logic             accept;

  assign SEL = (mode == MODE_RR) ? ptr : dest;

  // Strict round-robin: only the selected channel's space matters, so a
  // full pointed-at channel stalls the input even if others are free.
  assign in_ready = ~rst & space[SEL];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load[SEL] = 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    demux_chan_reg #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .d     (A),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .q     (q[i]),
      .space (space[i])
    );
  end

  assign W = q[CH_W];
  assign X = q[CH_X];
  assign Y = q[CH_Y];
  assign Z = q[CH_Z];

  // The pointer only moves on round-robin accepts, so directed traffic
  // leaves it parked and round-robin resumes where it stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= CH_W;
    end else if (accept && (mode == MODE_RR)) begin
      ptr <= ptr + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

endmodule
